// File: rtl/controller_report_bridge.sv
// controller_report_bridge: Avalon-MM slave buffering raw gamepad reports in a
// small FIFO and applying at most one per video frame to controller_report.
// Also produces per-bit press pulses and clears the report when the driver
// goes silent for a programmable number of frames.
module controller_report_bridge #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter int unsigned TIMEOUT_DEFAULT = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] writedata,
   input  logic        write,
   input  logic        chipselect,
   input  logic [2:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   input  logic        frame_tick,
   output logic [7:0]  controller_report,
   output logic [7:0]  button_press,
   output logic        stale
);

   localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = AW + 1;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]    head, tail;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;
   logic             enable;
   logic [7:0]       timeout;
   logic [7:0]       frame_cnt;

   logic             acc_wr, push, ctrl_wr, clear, to_wr, full;
   logic             frame_ev, pop, push_ok, ovf_set;
   logic [7:0]       cnt_inc;
   logic [7:0]       report_next, frame_cnt_next;
   logic             stale_next;
   logic [31:0]      rd_mux;

   // Decode bus accesses and work out the next report/stale/frame-counter values
   always_comb begin
      acc_wr   = write & chipselect;
      push     = acc_wr & (address == 3'd0);
      ctrl_wr  = acc_wr & (address == 3'd1);
      to_wr    = acc_wr & (address == 3'd4);
      clear    = ctrl_wr & writedata[1];
      full     = (fifo_count == CNT_W'(FIFO_DEPTH));
      frame_ev = frame_tick & enable & ~clear;
      pop      = frame_ev & (fifo_count != '0);
      push_ok  = push & (~full | pop);
      ovf_set  = push & full & ~pop;
      cnt_inc  = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;

      report_next    = controller_report;
      stale_next     = stale;
      frame_cnt_next = frame_cnt;
      if (clear) begin
         report_next    = '0;
         stale_next     = 1'b0;
         frame_cnt_next = '0;
      end else if (pop) begin
         report_next    = mem[head];
         stale_next     = 1'b0;
         frame_cnt_next = '0;
      end else if (frame_ev) begin
         frame_cnt_next = cnt_inc;
         // >= so a timeout lowered below the running count still takes effect
         if ((timeout != 8'd0) && (cnt_inc >= timeout)) begin
            report_next = '0;
            stale_next  = 1'b1;
         end
      end
   end

   // Read data multiplexer; unmapped addresses read as zero
   always_comb begin
      rd_mux = '0;
      case (address)
         3'd2:    rd_mux = {25'd0, enable, stale, overflow, 4'(fifo_count)};
         3'd3:    rd_mux = {24'd0, controller_report};
         default: rd_mux = '0;
      endcase
   end

   // FIFO storage; contents are don't-care whenever count says empty
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[tail] <= writedata[7:0];
   end

   // Pointers, flags, configuration, report and registered read data
   always_ff @(posedge clk) begin
      if (!reset) begin
         head              <= '0;
         tail              <= '0;
         fifo_count        <= '0;
         overflow          <= 1'b0;
         enable            <= 1'b1;
         timeout           <= 8'(TIMEOUT_DEFAULT);
         frame_cnt         <= '0;
         controller_report <= '0;
         button_press      <= '0;
         stale             <= 1'b0;
         readdata          <= '0;
      end else begin
         if (clear) begin
            head       <= '0;
            tail       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
         end else begin
            if (push_ok)
               tail <= tail + AW'(1);
            if (pop)
               head <= head + AW'(1);
            if (push_ok && !pop)
               fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push_ok)
               fifo_count <= fifo_count - CNT_W'(1);
            if (ovf_set)
               overflow <= 1'b1;
         end
         if (ctrl_wr)
            enable <= writedata[0];
         if (to_wr)
            timeout <= writedata[7:0];
         frame_cnt         <= frame_cnt_next;
         stale             <= stale_next;
         controller_report <= report_next;
         button_press      <= report_next & ~controller_report;
         if (read && chipselect)
            readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_controller_report_bridge.sv
// Directed self-checking bench for controller_report_bridge.
module tb_controller_report_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] writedata;
   logic        write;
   logic        chipselect;
   logic [2:0]  address;
   logic        read;
   logic [31:0] readdata;
   logic        frame_tick;
   logic [7:0]  controller_report;
   logic [7:0]  button_press;
   logic        stale;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] rdv;

   controller_report_bridge #(.FIFO_DEPTH(4), .TIMEOUT_DEFAULT(60)) dut (
      .clk(clk), .reset(reset), .writedata(writedata), .write(write),
      .chipselect(chipselect), .address(address), .read(read),
      .readdata(readdata), .frame_tick(frame_tick),
      .controller_report(controller_report), .button_press(button_press),
      .stale(stale)
   );

   always #5 clk = ~clk;

   // inputs change and outputs are sampled on the falling edge
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      write = 1'b1; chipselect = 1'b1; address = a; writedata = d;
      cycle();
      write = 1'b0; chipselect = 1'b0; writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      read = 1'b1; chipselect = 1'b1; address = a;
      cycle();
      read = 1'b0; chipselect = 1'b0;
      d = readdata;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [7:0] rep, input logic [7:0] bp, input logic st);
      check({tag, ".report"}, {24'd0, controller_report}, {24'd0, rep});
      check({tag, ".press"},  {24'd0, button_press},      {24'd0, bp});
      check({tag, ".stale"},  {31'd0, stale},             {31'd0, st});
   endtask

   initial begin
      reset = 1'b0; writedata = '0; write = 1'b0; chipselect = 1'b0;
      address = '0; read = 1'b0; frame_tick = 1'b0;
      @(negedge clk);
      cycle();
      cycle();
      reset = 1'b1;

      // reset state
      check_out("reset", 8'h00, 8'h00, 1'b0);
      check("reset.readdata", readdata, 32'h0);
      rd(3'd2, rdv); check("reset.status", rdv, 32'h40);

      // single report applied on a frame tick
      wr(3'd0, 32'h10);
      rd(3'd2, rdv); check("one.status_before", rdv, 32'h41);
      tick();       check_out("one.pop", 8'h10, 8'h10, 1'b0);
      cycle();      check_out("one.after", 8'h10, 8'h00, 1'b0);
      rd(3'd2, rdv); check("one.status", rdv, 32'h40);
      rd(3'd3, rdv); check("one.report_now", rdv, 32'h10);
      rd(3'd5, rdv); check("unmapped.read", rdv, 32'h0);

      // overflow: five pushes into a four-deep FIFO
      wr(3'd0, 32'h01); wr(3'd0, 32'h02); wr(3'd0, 32'h03);
      wr(3'd0, 32'h04); wr(3'd0, 32'h05);
      rd(3'd2, rdv); check("ovf.status", rdv, 32'h54);
      tick(); check_out("ovf.pop1", 8'h01, 8'h01, 1'b0);
      tick(); check_out("ovf.pop2", 8'h02, 8'h02, 1'b0);
      tick(); check_out("ovf.pop3", 8'h03, 8'h01, 1'b0);
      tick(); check_out("ovf.pop4", 8'h04, 8'h04, 1'b0);
      rd(3'd2, rdv); check("ovf.status_empty", rdv, 32'h50);
      wr(3'd1, 32'h3); check_out("clear", 8'h00, 8'h00, 1'b0);
      rd(3'd2, rdv); check("clear.status", rdv, 32'h40);

      // stale timeout of three frames
      wr(3'd4, 32'h3);
      wr(3'd0, 32'h08);
      tick(); check_out("to.apply", 8'h08, 8'h08, 1'b0);
      tick(); check_out("to.tick1", 8'h08, 8'h00, 1'b0);
      tick(); check_out("to.tick2", 8'h08, 8'h00, 1'b0);
      tick(); check_out("to.tick3", 8'h00, 8'h00, 1'b1);
      rd(3'd2, rdv); check("to.status", rdv, 32'h60);
      wr(3'd0, 32'h08);
      tick(); check_out("to.recover", 8'h08, 8'h08, 1'b0);

      // push and pop in the same cycle with a full FIFO
      wr(3'd0, 32'h11); wr(3'd0, 32'h22); wr(3'd0, 32'h33); wr(3'd0, 32'h44);
      write = 1'b1; chipselect = 1'b1; address = 3'd0; writedata = 32'h55;
      frame_tick = 1'b1;
      cycle();
      write = 1'b0; chipselect = 1'b0; frame_tick = 1'b0;
      check_out("full.pushpop", 8'h11, 8'h11, 1'b0);
      rd(3'd2, rdv); check("full.status", rdv, 32'h44);
      tick(); check_out("full.pop", 8'h22, 8'h22, 1'b0);
      rd(3'd2, rdv); check("full.status3", rdv, 32'h43);

      // reset with three entries queued
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      check_out("rst2", 8'h00, 8'h00, 1'b0);
      check("rst2.readdata", readdata, 32'h0);
      tick(); check_out("rst2.tick", 8'h00, 8'h00, 1'b0);
      rd(3'd2, rdv); check("rst2.status", rdv, 32'h40);

      // enable=0 freezes the report but still accepts pushes
      wr(3'd1, 32'h0);
      wr(3'd0, 32'h77);
      tick(); check_out("dis.tick", 8'h00, 8'h00, 1'b0);
      rd(3'd2, rdv); check("dis.status", rdv, 32'h01);
      wr(3'd1, 32'h1);
      tick(); check_out("en.tick", 8'h77, 8'h77, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
